// File: rtl/xadc_drp_scheduler.sv
// Round-robin XADC DRP reader for VAUX6/7/14/15, paced by end-of-conversion.
// Define AVG4_EN to report the truncated mean of every four samples per slot.
module xadc_drp_scheduler #(
   parameter logic [6:0]  ADDR0   = 7'h16,
   parameter logic [6:0]  ADDR1   = 7'h17,
   parameter logic [6:0]  ADDR2   = 7'h1E,
   parameter logic [6:0]  ADDR3   = 7'h1F,
   parameter int unsigned TIMEOUT = 255
) (
   input  logic        CLK100MHZ,
   input  logic        rst,
   input  logic        en,
   input  logic [3:0]  ch_mask,
   input  logic        eoc_in,
   input  logic        drdy_in,
   input  logic [15:0] do_in,
   output logic [6:0]  daddr_out,
   output logic        den_out,
   output logic        dwe_out,
   output logic [47:0] results_out,
   output logic [11:0] sample_out,
   output logic [1:0]  sample_ch,
   output logic        sample_valid,
   output logic        timeout_err,
   output logic        busy
);

   typedef enum logic [2:0] {
      IDLE, WAIT_EOC, ISSUE, WAIT_RDY, STORE
   } state_t;

   localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

   state_t      state_q, state_d;
   logic [1:0]  ptr_q, ptr_d;
   logic [6:0]  daddr_q, daddr_d;
   logic [7:0]  cnt_q, cnt_d;
   logic [47:0] res_q, res_d;
   logic [11:0] smp_q, smp_d;
   logic [1:0]  sch_q, sch_d;
   logic        sv_q, sv_d;
   logic        terr_q, terr_d;
   logic        wr;
   logic [11:0] val;
   logic [11:0] smp;
   logic        unused_nibble;

`ifdef AVG4_EN
   logic [13:0] acc_q [4];
   logic [13:0] acc_d [4];
   logic [1:0]  n_q [4];
   logic [1:0]  n_d [4];
   logic [13:0] sum;
`endif

   assign smp = do_in[15:4];
   assign unused_nibble = ^do_in[3:0];

   // First enabled slot after p, wrapping; p itself is the last candidate.
   function automatic logic [1:0] next_slot(
      input logic [1:0] p,
      input logic [3:0] m
   );
      logic [1:0] s;
      logic [1:0] idx;
      s = p;
      for (int i = 4; i >= 1; i--) begin
         idx = p + 2'(i);
         if (m[idx]) s = idx;
      end
      return s;
   endfunction

   function automatic logic [6:0] slot_addr(input logic [1:0] s);
      logic [6:0] a;
      unique case (s)
         2'd0: a = ADDR0;
         2'd1: a = ADDR1;
         2'd2: a = ADDR2;
         default: a = ADDR3;
      endcase
      return a;
   endfunction

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      daddr_d = daddr_q;
      cnt_d   = cnt_q;
      res_d   = res_q;
      smp_d   = smp_q;
      sch_d   = sch_q;
      sv_d    = 1'b0;
      terr_d  = 1'b0;
      wr      = 1'b0;
      val     = smp;
`ifdef AVG4_EN
      acc_d = acc_q;
      n_d   = n_q;
      sum   = acc_q[ptr_q] + {2'b00, smp};
`endif
      unique case (state_q)
         IDLE: begin
            if (en && ch_mask != 4'd0) state_d = WAIT_EOC;
         end
         WAIT_EOC: begin
            if (!en || ch_mask == 4'd0) begin
               state_d = IDLE;
            end else if (eoc_in) begin
               ptr_d   = next_slot(ptr_q, ch_mask);
               daddr_d = slot_addr(ptr_d);
               state_d = ISSUE;
            end
         end
         ISSUE: begin
            cnt_d   = 8'd0;
            state_d = WAIT_RDY;
         end
         WAIT_RDY: begin
            cnt_d = cnt_q + 8'd1;
            if (drdy_in) begin
               state_d = STORE;
`ifdef AVG4_EN
               if (n_q[ptr_q] == 2'd3) begin
                  wr            = 1'b1;
                  val           = sum[13:2];
                  acc_d[ptr_q]  = '0;
                  n_d[ptr_q]    = '0;
               end else begin
                  acc_d[ptr_q]  = sum;
                  n_d[ptr_q]    = n_q[ptr_q] + 2'd1;
               end
`else
               wr = 1'b1;
`endif
            end else if (cnt_q == TMO_LAST) begin
               terr_d  = 1'b1;
               state_d = en ? WAIT_EOC : IDLE;
            end
         end
         STORE: begin
            state_d = en ? WAIT_EOC : IDLE;
         end
         default: state_d = IDLE;
      endcase
      // Outputs land on the drdy edge so they coincide with the STORE strobe.
      if (wr) begin
         for (int i = 0; i < 4; i++) begin
            if (ptr_q == 2'(i)) res_d[12*i +: 12] = val;
         end
         smp_d = val;
         sch_d = ptr_q;
         sv_d  = 1'b1;
      end
   end

   always_ff @(posedge CLK100MHZ) begin
      if (rst) begin
         state_q <= IDLE;
         ptr_q   <= 2'd3;
         daddr_q <= ADDR0;
         cnt_q   <= '0;
         res_q   <= '0;
         smp_q   <= '0;
         sch_q   <= '0;
         sv_q    <= 1'b0;
         terr_q  <= 1'b0;
`ifdef AVG4_EN
         acc_q   <= '{default: '0};
         n_q     <= '{default: '0};
`endif
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         daddr_q <= daddr_d;
         cnt_q   <= cnt_d;
         res_q   <= res_d;
         smp_q   <= smp_d;
         sch_q   <= sch_d;
         sv_q    <= sv_d;
         terr_q  <= terr_d;
`ifdef AVG4_EN
         acc_q   <= acc_d;
         n_q     <= n_d;
`endif
      end
   end

   assign daddr_out    = daddr_q;
   assign den_out      = (state_q == ISSUE);
   assign dwe_out      = 1'b0;
   assign results_out  = res_q;
   assign sample_out   = smp_q;
   assign sample_ch    = sch_q;
   assign sample_valid = sv_q;
   assign timeout_err  = terr_q;
   assign busy         = (state_q == ISSUE) || (state_q == WAIT_RDY);

endmodule
